// File: rtl/clf_stream_seq.sv
// clf_stream_seq: sequential wrapper around a combinational classifier core.
// Handshakes: a beat moves on in_valid && in_ready, a result moves on
// res_valid && res_ready; in_ready and res_valid are pure decodes of state_q,
// so neither depends combinationally on in_valid or res_ready.
// Flow: LOAD collects NUM_A features, SETTLE holds cls_inp stable and then
// captures cls_out, ARGMAX (NUM_CLS>1 only) picks the highest score field,
// and HOLD presents the result until it is taken.
module clf_stream_seq #(
  parameter int WIDTH_A  = 4,
  parameter int NUM_A    = 21,
  parameter int OUTWIDTH = 22,
  parameter int NUM_CLS  = 1,
  parameter int SETTLE   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH_A-1:0]         in_data,
  input  logic                       in_last,
  output logic [NUM_A*WIDTH_A-1:0]   cls_inp,
  input  logic [OUTWIDTH-1:0]        cls_out,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [OUTWIDTH-1:0]        res_raw,
  output logic [((NUM_CLS > 1) ? $clog2(NUM_CLS) : 1)-1:0] res_class,
  output logic                       res_err
);

  localparam int FW = OUTWIDTH / NUM_CLS;
  localparam int CW = (NUM_CLS > 1) ? $clog2(NUM_CLS) : 1;
  localparam int IW = (NUM_A > 1) ? $clog2(NUM_A) : 1;
  localparam int SW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ARGMAX = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // state_q is the observable FSM state for external checkers.
  state_t              state_q, state_d;
  logic [IW-1:0]       cnt_q, cnt_d;
  logic [WIDTH_A-1:0]  feat_q [NUM_A];
  logic [WIDTH_A-1:0]  feat_d [NUM_A];
  logic                err_q, err_d;
  logic [SW-1:0]       settle_q, settle_d;
  logic [OUTWIDTH-1:0] raw_q, raw_d;
  logic [CW-1:0]       class_q, class_d;
  logic [CW-1:0]       arg_j_q, arg_j_d;
  logic [FW-1:0]       best_val_q, best_val_d;
  logic [CW-1:0]       best_idx_q, best_idx_d;

  logic [FW-1:0]       field_sel;
  logic [FW-1:0]       win_val;
  logic [CW-1:0]       win_idx;

  // Next-state, datapath and counter updates for all four states.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    feat_d     = feat_q;
    err_d      = err_q;
    settle_d   = settle_q;
    raw_d      = raw_q;
    class_d    = class_q;
    arg_j_d    = arg_j_q;
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    field_sel  = FW'(raw_q >> (FW * int'(arg_j_q)));
    win_val    = best_val_q;
    win_idx    = best_idx_q;

    case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          for (int i = 0; i < NUM_A; i++) begin
            if (IW'(i) == cnt_q) feat_d[i] = in_data;
          end
          if (cnt_q == IW'(NUM_A - 1)) begin
            // Full count reached; a missing last marker is a framing error.
            state_d  = ST_SETTLE;
            settle_d = '0;
            if (!in_last) err_d = 1'b1;
          end else if (in_last) begin
            // Early last: blank the unfilled tail so the core sees zeros.
            for (int i = 0; i < NUM_A; i++) begin
              if (IW'(i) > cnt_q) feat_d[i] = '0;
            end
            err_d    = 1'b1;
            state_d  = ST_SETTLE;
            settle_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_SETTLE: begin
        // The final feature lands on the entry edge; the vector is then held
        // for SETTLE further cycles and cls_out is sampled on the edge after.
        if (settle_q == SW'(SETTLE)) begin
          raw_d    = cls_out;
          settle_d = '0;
          if (NUM_CLS == 1) begin
            state_d = ST_HOLD;
          end else begin
            state_d    = ST_ARGMAX;
            best_val_d = cls_out[FW-1:0];
            best_idx_d = '0;
            arg_j_d    = CW'(1);
          end
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end

      ST_ARGMAX: begin
        // Strict greater-than keeps the lowest index on ties.
        if (field_sel > best_val_q) begin
          win_val = field_sel;
          win_idx = arg_j_q;
        end
        best_val_d = win_val;
        best_idx_d = win_idx;
        if (arg_j_q == CW'(NUM_CLS - 1)) begin
          class_d = win_idx;
          arg_j_d = '0;
          state_d = ST_HOLD;
        end else begin
          arg_j_d = arg_j_q + 1'b1;
        end
      end

      ST_HOLD: begin
        if (res_ready) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end

      default: state_d = ST_LOAD;
    endcase
  end

  // State and datapath registers; reset discards any partial sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOAD;
      cnt_q      <= '0;
      for (int i = 0; i < NUM_A; i++) feat_q[i] <= '0;
      err_q      <= 1'b0;
      settle_q   <= '0;
      raw_q      <= '0;
      class_q    <= '0;
      arg_j_q    <= '0;
      best_val_q <= '0;
      best_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      feat_q     <= feat_d;
      err_q      <= err_d;
      settle_q   <= settle_d;
      raw_q      <= raw_d;
      class_q    <= class_d;
      arg_j_q    <= arg_j_d;
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
    end
  end

  // Pack feature registers into the core input vector.
  always_comb begin
    cls_inp = '0;
    for (int i = 0; i < NUM_A; i++) begin
      cls_inp[i*WIDTH_A +: WIDTH_A] = feat_q[i];
    end
  end

  assign in_ready  = (state_q == ST_LOAD);
  assign res_valid = (state_q == ST_HOLD);
  assign res_raw   = raw_q;
  assign res_class = class_q;
  assign res_err   = err_q;

endmodule

// File: tb/tb_clf_stream_seq.sv
// Directed bench for clf_stream_seq: one default instance (single score
// field, core modelled by core_f) and one NUM_CLS=2 instance whose core
// output is driven directly with hand-picked score pairs.
module tb_clf_stream_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_last, res_ready;
  logic [3:0]  in_data;
  logic        en1, en2;
  int          sel;

  logic        ready1, ready2, rv1, rv2;
  logic [83:0] cls_inp1, cls_inp2;
  logic [21:0] cls_out1, cls_out2;
  logic [21:0] raw1, raw2;
  logic [0:0]  class1, class2;
  logic        err1, err2;

  int          total = 0;
  int          bad = 0;
  logic [3:0]  beat_v [21];
  logic [21:0] exp_q [$];
  logic [83:0] last_exp_vec;
  logic [21:0] last_exp_raw;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog");
  end

  // Reference model of the combinational core.
  function automatic logic [21:0] core_f(input logic [83:0] v);
    logic [21:0] acc;
    acc = '0;
    for (int i = 0; i < 21; i++) begin
      acc = {acc[20:0], acc[21]} ^ (22'(v[i*4 +: 4]) * 22'(i + 1));
    end
    return acc;
  endfunction

  assign cls_out1 = core_f(cls_inp1);

  clf_stream_seq dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid & en1), .in_ready(ready1), .in_data(in_data), .in_last(in_last),
    .cls_inp(cls_inp1), .cls_out(cls_out1),
    .res_valid(rv1), .res_ready(res_ready), .res_raw(raw1), .res_class(class1), .res_err(err1)
  );

  clf_stream_seq #(.NUM_CLS(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid & en2), .in_ready(ready2), .in_data(in_data), .in_last(in_last),
    .cls_inp(cls_inp2), .cls_out(cls_out2),
    .res_valid(rv2), .res_ready(res_ready), .res_raw(raw2), .res_class(class2), .res_err(err2)
  );

  function automatic logic cur_ready();
    return (sel != 0) ? ready2 : ready1;
  endfunction
  function automatic logic cur_valid();
    return (sel != 0) ? rv2 : rv1;
  endfunction
  function automatic logic [83:0] cur_vec();
    return (sel != 0) ? cls_inp2 : cls_inp1;
  endfunction
  function automatic logic [21:0] cur_raw();
    return (sel != 0) ? raw2 : raw1;
  endfunction
  function automatic logic cur_class();
    return (sel != 0) ? class2[0] : class1[0];
  endfunction
  function automatic logic cur_err();
    return (sel != 0) ? err2 : err1;
  endfunction

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Streams beats 0..nbeats-1 from beat_v; in_last on index last_idx.
  task automatic send_sample(input int nbeats, input int last_idx);
    int guard;
    for (int k = 0; k < nbeats; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = beat_v[k];
      in_last  = (k == last_idx);
      guard = 0;
      while (!cur_ready() && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (!cur_ready()) chk("beat_ready_timeout", 0, 1);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Counts edges after the final beat until res_valid is seen.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!cur_valid() && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!cur_valid()) chk("result_timeout", 0, 1);
  endtask

  task automatic run_case(input string tag, input int nbeats, input int last_idx,
                          input logic exp_err, input logic exp_class, input int exp_lat);
    logic [83:0] ev;
    logic [21:0] er;
    int          eff;
    int          lat;
    eff = (last_idx < 0) ? 20 : last_idx;
    ev = '0;
    for (int i = 0; i < 21; i++) begin
      if (i <= eff) ev[i*4 +: 4] = beat_v[i];
    end
    er = (sel != 0) ? cls_out2 : core_f(ev);
    exp_q.push_back(er);
    last_exp_vec = ev;
    last_exp_raw = er;
    send_sample(nbeats, last_idx);
    wait_result(lat);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_inp"}, cur_vec(), ev);
    chk({tag, "_raw"}, cur_raw(), exp_q.pop_front());
    chk({tag, "_class"}, cur_class(), exp_class);
    chk({tag, "_err"}, cur_err(), exp_err);
    if (res_ready) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_ready_back"}, cur_ready(), 1);
      chk({tag, "_valid_drop"}, cur_valid(), 0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    res_ready = 1'b1; en1 = 1'b1; en2 = 1'b0; sel = 0;
    cls_out2 = '0;
    repeat (2) @(negedge clk);
    chk("rst_inp", cls_inp1, 0);
    chk("rst_valid", rv1, 0);
    chk("rst_ready", ready1, 1);
    chk("rst_raw", raw1, 0);
    chk("rst_class", class1, 0);
    chk("rst_err", err1, 0);
    chk("rst_valid2", rv2, 0);
    rst_n = 1'b1;

    // Basic sample: values 0..20 mod 16.
    for (int i = 0; i < 21; i++) beat_v[i] = 4'(i % 16);
    run_case("basic", 21, 20, 0, 0, 3);

    // Early last on index 4 with value 9; tail must be zeroed.
    for (int i = 0; i < 21; i++) beat_v[i] = 4'd9;
    run_case("early", 5, 4, 1, 0, 3);

    // Missing last, then a correctly framed sample.
    for (int i = 0; i < 21; i++) beat_v[i] = 4'((i * 5 + 3) % 16);
    run_case("nolast", 21, -1, 1, 0, 3);
    for (int i = 0; i < 21; i++) beat_v[i] = 4'((i ^ 7) % 16);
    run_case("after_nolast", 21, 20, 0, 0, 3);

    // Result held off for 10 cycles while in_valid stays high.
    res_ready = 1'b0;
    for (int i = 0; i < 21; i++) beat_v[i] = 4'((3 * i + 1) % 16);
    run_case("hold", 21, 20, 0, 0, 3);
    in_valid = 1'b1;
    in_data  = 4'hF;
    in_last  = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_ready", ready1, 0);
      chk("hold_valid", rv1, 1);
      chk("hold_raw", raw1, last_exp_raw);
    end
    chk("hold_inp", cls_inp1, last_exp_vec);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("hold_release_ready", ready1, 1);
    in_valid = 1'b0;

    // Asynchronous reset after 10 beats of an unfinished sample.
    for (int i = 0; i < 21; i++) beat_v[i] = 4'hA;
    send_sample(10, -1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_inp", cls_inp1, 0);
    chk("arst_valid", rv1, 0);
    chk("arst_ready", ready1, 1);
    chk("arst_err", err1, 0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 21; i++) beat_v[i] = 4'((20 - i) % 16);
    run_case("post_rst", 21, 20, 0, 0, 3);

    // Two score fields, argmax path.
    sel = 1; en1 = 1'b0; en2 = 1'b1;
    for (int i = 0; i < 21; i++) beat_v[i] = 4'((i * 7) % 16);
    cls_out2 = {11'd200, 11'd100};
    run_case("arg_gt", 21, 20, 0, 1, 4);
    cls_out2 = {11'd300, 11'd300};
    run_case("arg_tie", 21, 20, 0, 0, 4);
    cls_out2 = {11'd7, 11'd500};
    run_case("arg_lt", 21, 20, 0, 0, 4);
    cls_out2 = {11'd2047, 11'd2046};
    run_case("arg_max", 21, 20, 0, 1, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clf_stream_seq.md
Name: clf_stream_seq

Overview:
- Sequential front/back end for a combinational printed classifier core.
- Collects NUM_A features of WIDTH_A bits, one per beat, over a valid/ready stream, then drives them as a packed vector to the core.
- Waits a fixed settle time, then captures the core's OUTWIDTH-bit output.
- Optionally reduces that output to a class index by sequential argmax over NUM_CLS score fields, and returns the raw output and the class through a valid/ready result port.

Parameters:
- WIDTH_A, 4: bits per feature.
- NUM_A, 21: features per sample.
- OUTWIDTH, 22: width of the core output. Must be divisible by NUM_CLS.
- NUM_CLS, 1: number of unsigned score fields in the core output. 1 disables argmax.
- SETTLE, 2: cycles the packed vector is held stable before capture. Must be ≥1.
- Localparams:
  - FW = OUTWIDTH/NUM_CLS.
  - CW = max(1, clog2(NUM_CLS)).
  - IW = max(1, clog2(NUM_A)).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  feature beat valid.
- in_ready  out  1  block accepts a feature beat.
- in_data  in  WIDTH_A  feature value; beat k is feature index k.
- in_last  in  1  marks the final feature of a sample.
- cls_inp  out  NUM_A*WIDTH_A  packed features to the core; feature i occupies [(i+1)*WIDTH_A-1 : i*WIDTH_A].
- cls_out  in  OUTWIDTH  core output. Field j occupies [(j+1)*FW-1 : j*FW].
- res_valid  out  1  result available.
- res_ready  in  1  result consumed.
- res_raw  out  OUTWIDTH  captured cls_out.
- res_class  out  CW  argmax index; 0 when NUM_CLS=1.
- res_err  out  1  framing error in this sample.

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state goes to LOAD; feature count cleared.
  - Every feature register cleared, so cls_inp = 0.
  - res_raw, res_class, res_err, res_valid = 0; settle/argmax counters = 0.
  - in_ready = 1 once in LOAD.
  - A reset mid-sample or mid-result discards everything; no partial result is ever emitted.
- All outputs are registered or are pure decodes of state. There is no combinational path from in_valid or res_ready to in_ready or res_valid.
- A beat transfers when in_valid && in_ready. A result transfers when res_valid && res_ready.
- States: LOAD, SETTLE, ARGMAX, HOLD.
- LOAD:
  - in_ready = 1, res_valid = 0.
  - Each transfer writes in_data to feature[cnt].
  - Transfer with cnt < NUM_A-1 and in_last=0: cnt++.
  - Transfer with cnt = NUM_A-1: go to SETTLE. If in_last=0 on this beat, set the error flag (missing last).
  - Transfer with cnt < NUM_A-1 and in_last=1 (early last): features cnt+1..NUM_A-1 are zeroed in the same cycle, the error flag is set, and the state goes to SETTLE.
  - in_data is ignored when no transfer occurs.
- SETTLE:
  - Settle counter runs SETTLE cycles; cls_inp is unchanged.
  - On the last settle cycle, cls_out is captured into res_raw.
  - Next state is HOLD if NUM_CLS = 1, otherwise ARGMAX.
- ARGMAX:
  - Best starts as field 0 with index 0.
  - One field per cycle for j = 1..NUM_CLS-1, taking NUM_CLS-1 cycles, compared unsigned.
  - Replace only if field j > best (strict), so ties keep the lowest index.
  - After field NUM_CLS-1, res_class is updated and the state goes to HOLD.
- HOLD:
  - res_valid = 1; res_raw, res_class and res_err are stable; in_ready = 0 and in_valid is ignored.
  - On a result transfer: next state LOAD, cnt = 0, error flag cleared, res_valid = 0 next cycle.
  - res_raw and res_class keep their last values until overwritten. Feature registers keep their values until overwritten.
- Latency, with the final beat accepted at edge T:
  - NUM_CLS = 1: res_valid is 1 after edge T+SETTLE+1.
  - NUM_CLS > 1: res_valid is 1 after edge T+SETTLE+NUM_CLS.
  - After the result transfer, in_ready returns 1 on the next cycle.
- Simultaneous events: res_ready held high continuously gives back-to-back samples with exactly one LOAD-entry bubble and no lost beats.
- Widths: no arithmetic other than counters. The counters must not wrap: cnt saturates at NUM_A-1 by construction.

Test Plan:
- Defaults, 21 beats of values 0..20 mod 16, core modelled as a reference function, res_ready=1 → cls_inp nibble i = i mod 16; res_valid rises 3 cycles after the last beat; res_raw equals the model output; res_class = 0; res_err = 0.
- in_last asserted on beat 5 (index 4) with values 9 → features 0..4 = 9, features 5..20 = 0; res_err = 1; the result is still produced with normal latency.
- 21 beats with in_last never asserted → res_err = 1; a following correctly framed sample gives res_err = 0.
- NUM_CLS = 2, OUTWIDTH = 22, cls_out fields {f1, f0}:
  - f0 = 100, f1 = 200 → res_class = 1.
  - f0 = f1 = 300 → res_class = 0 (tie).
  - res_valid arrives one cycle later than in the NUM_CLS = 1 case.
- res_ready held low for 10 cycles in HOLD while in_valid=1 → in_ready stays 0, res_raw stays stable, no beats are consumed; releasing res_ready makes in_ready rise the next cycle.
- rst_n pulsed low asynchronously after beat 10 → cls_inp = 0, res_valid = 0, in_ready = 1; a full 21-beat sample afterwards is correct and unaffected by the aborted one.
